// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
// Bundles the two requester handshakes and the register-file write port.
//   a_valid/a_ready/a_addr/a_data : requester A (datapath writeback)
//   b_valid/b_ready/b_addr/b_data : requester B (loader/debug port)
//   we3/wa3/wd3                   : registered register-file write port
//   grant_b                       : source of the current write (1 = B)
//   drop_cnt                      : saturating count of writes to R0
// Modport slave is the arbiter side, master is the requester/observer side.
interface regfile_write_arbiter_if;
    logic       a_valid;
    logic       a_ready;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic       b_valid;
    logic       b_ready;
    logic [2:0] b_addr;
    logic [7:0] b_data;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic       grant_b;
    logic [7:0] drop_cnt;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output we3, wa3, wd3, grant_b, drop_cnt
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  we3, wa3, wd3, grant_b, drop_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between requesters A and B.
// Each requester owns a one-entry buffer; a two-way round-robin picks one
// buffered entry per cycle and drives registered we3/wa3/wd3. Entries
// addressed to R0 are consumed and counted in drop_cnt instead of issued.
// Ports:
//   clk  : single clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : regfile_write_arbiter_if.slave (handshakes + write port)
module regfile_write_arbiter (
    input  logic                         clk,
    input  logic                         rst,
    regfile_write_arbiter_if.slave       bus
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic [2:0] addr_a_q, addr_a_d;
    logic [2:0] addr_b_q, addr_b_d;
    logic [7:0] data_a_q, data_a_d;
    logic [7:0] data_b_q, data_b_d;
    logic       last_b_q, last_b_d;
    logic       we3_q, we3_d;
    logic [2:0] wa3_q, wa3_d;
    logic [7:0] wd3_q, wd3_d;
    logic       grant_b_q, grant_b_d;
    logic [7:0] drop_q, drop_d;

    logic       sel_a, sel_b;
    logic       acc_a, acc_b;
    logic [2:0] sel_addr;
    logic [7:0] sel_data;

    // Selection and ready depend only on state, never on the valids.
    always_comb begin
        sel_a    = pend_a_q & (~pend_b_q | last_b_q);
        sel_b    = pend_b_q & (~pend_a_q | ~last_b_q);
        sel_addr = sel_b ? addr_b_q : addr_a_q;
        sel_data = sel_b ? data_b_q : data_a_q;
        // A buffer being drained this edge can be refilled at the same edge.
        bus.a_ready = ~pend_a_q | sel_a;
        bus.b_ready = ~pend_b_q | sel_b;
        acc_a    = bus.a_valid & bus.a_ready;
        acc_b    = bus.b_valid & bus.b_ready;
    end

    always_comb begin
        pend_a_d  = pend_a_q;
        pend_b_d  = pend_b_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        last_b_d  = last_b_q;
        we3_d     = 1'b0;
        wa3_d     = wa3_q;
        wd3_d     = wd3_q;
        grant_b_d = grant_b_q;
        drop_d    = drop_q;

        if (acc_a) begin
            pend_a_d = 1'b1;
            addr_a_d = bus.a_addr;
            data_a_d = bus.a_data;
        end else if (sel_a) begin
            pend_a_d = 1'b0;
        end

        if (acc_b) begin
            pend_b_d = 1'b1;
            addr_b_d = bus.b_addr;
            data_b_d = bus.b_data;
        end else if (sel_b) begin
            pend_b_d = 1'b0;
        end

        // R0 drops still take their turn, so they advance last_b too.
        if (sel_a | sel_b) begin
            last_b_d = sel_b;
            if (sel_addr != 3'd0) begin
                we3_d     = 1'b1;
                wa3_d     = sel_addr;
                wd3_d     = sel_data;
                grant_b_d = sel_b;
            end else begin
                drop_d = sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_a_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            last_b_q  <= 1'b1;
            we3_q     <= 1'b0;
            wa3_q     <= 3'd0;
            wd3_q     <= 8'd0;
            grant_b_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            pend_a_q  <= pend_a_d;
            pend_b_q  <= pend_b_d;
            last_b_q  <= last_b_d;
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            grant_b_q <= grant_b_d;
            drop_q    <= drop_d;
        end
    end

    // Buffer contents are qualified by the pend bits, so they need no reset.
    always_ff @(posedge clk) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        data_a_q <= data_a_d;
        data_b_q <= data_b_d;
    end

    assign bus.we3      = we3_q;
    assign bus.wa3      = wa3_q;
    assign bus.wd3      = wd3_q;
    assign bus.grant_b  = grant_b_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one-deep pending queues per requester, grant history,
    // drop count, and the queue of writes expected on the port next cycle.
    typedef struct packed { logic gb; logic [2:0] a; logic [7:0] d; } wr_t;
    wr_t        pa[$];
    wr_t        pb[$];
    wr_t        exp_q[$];
    logic       m_last_b;
    int         m_drop;
    logic       started = 1'b0;

    logic [7:0] rf [8];
    always @(posedge clk) if (bus.we3 === 1'b1) rf[bus.wa3] <= bus.wd3;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_sel_a();
        return (pa.size() != 0) && ((pb.size() == 0) || m_last_b);
    endfunction

    function automatic bit m_sel_b();
        return (pb.size() != 0) && ((pa.size() == 0) || !m_last_b);
    endfunction

    // One clock cycle: drive inputs, check ready/drop_cnt, then advance model.
    task automatic step(input logic r,
                        input logic va, input logic [2:0] aa, input logic [7:0] ad,
                        input logic vb, input logic [2:0] ba, input logic [7:0] bd,
                        output logic acc_a, output logic acc_b);
        bit sa, sb, ra, rb;
        wr_t e;
        rst         = r;
        bus.a_valid = va; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = vb; bus.b_addr = ba; bus.b_data = bd;
        @(negedge clk);
        sa = m_sel_a();
        sb = m_sel_b();
        ra = (pa.size() == 0) || sa;
        rb = (pb.size() == 0) || sb;
        check(bus.a_ready === ra, "a_ready", int'(bus.a_ready), int'(ra));
        check(bus.b_ready === rb, "b_ready", int'(bus.b_ready), int'(rb));
        check(bus.drop_cnt === 8'(m_drop), "drop_cnt", int'(bus.drop_cnt), m_drop);
        acc_a = va & ra;
        acc_b = vb & rb;
        @(posedge clk);
        #1;
        if (r) begin
            pa.delete(); pb.delete();
            m_last_b = 1'b1;
            m_drop   = 0;
        end else begin
            if (sa) begin
                e = pa.pop_front();
                m_last_b = 1'b0;
                if (e.a == 3'd0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else exp_q.push_back('{gb: 1'b0, a: e.a, d: e.d});
            end
            if (sb) begin
                e = pb.pop_front();
                m_last_b = 1'b1;
                if (e.a == 3'd0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else exp_q.push_back('{gb: 1'b1, a: e.a, d: e.d});
            end
            if (acc_a) pa.push_back('{gb: 1'b0, a: aa, d: ad});
            if (acc_b) pb.push_back('{gb: 1'b1, a: ba, d: bd});
        end
    endtask

    task automatic idle(input int n);
        logic x, y;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, x, y);
    endtask

    // Monitor: every cycle the port must show exactly what the model issued,
    // and hold its last address/data/source while idle.
    initial begin : monitor
        logic       r_edge;
        logic [2:0] h_wa;
        logic [7:0] h_wd;
        logic       h_gb;
        wr_t        e;
        h_wa = 3'd0; h_wd = 8'd0; h_gb = 1'b0;
        wait (started);
        forever begin
            @(posedge clk);
            r_edge = rst;
            @(negedge clk);
            if (r_edge) begin h_wa = 3'd0; h_wd = 8'd0; h_gb = 1'b0; end
            check(bus.we3 === (exp_q.size() != 0), "we3", int'(bus.we3), int'(exp_q.size() != 0));
            if (bus.we3 === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                h_wa = e.a; h_wd = e.d; h_gb = e.gb;
            end
            check(bus.wa3 === h_wa, "wa3", int'(bus.wa3), int'(h_wa));
            check(bus.wd3 === h_wd, "wd3", int'(bus.wd3), int'(h_wd));
            check(bus.grant_b === h_gb, "grant_b", int'(bus.grant_b), int'(h_gb));
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic x, y;
        logic ha, hb;
        logic [2:0] ra_, rb_;
        logic [7:0] da_, db_;
        int   n;

        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_addr = 3'd0; bus.a_data = 8'd0;
        bus.b_valid = 1'b0; bus.b_addr = 3'd0; bus.b_data = 8'd0;
        m_last_b = 1'b1;
        m_drop   = 0;
        @(posedge clk);
        #1;
        started = 1'b1;

        // Reset then idle
        step(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, x, y);
        idle(5);

        // Single write from A
        step(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'd0, x, y);
        check(x === 1'b1, "single_accept", int'(x), 1);
        idle(3);
        check(rf[3] === 8'h5A, "rf_r3", int'(rf[3]), 8'h5A);

        // Contention
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, x, y);
        idle(4);
        check(rf[1] === 8'h11, "rf_r1", int'(rf[1]), 8'h11);
        check(rf[2] === 8'h22, "rf_r2", int'(rf[2]), 8'h22);

        // B streaming
        n = 0;
        for (int i = 0; i < 12 && n < 4; i++) begin
            step(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'(4 + n), 8'(8'h40 + n), x, y);
            if (y) n++;
        end
        check(n == 4, "stream_count", n, 4);
        idle(3);
        check(rf[7] === 8'h43, "rf_r7", int'(rf[7]), 8'h43);

        // R0 drops
        n = 0;
        for (int i = 0; i < 12 && n < 3; i++) begin
            step(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'd0, x, y);
            if (x) n++;
        end
        idle(2);
        check(bus.drop_cnt === 8'd3, "drop_3", int'(bus.drop_cnt), 3);
        n = 0;
        for (int i = 0; i < 400 && n < 300; i++) begin
            step(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'd0, x, y);
            if (x) n++;
        end
        idle(2);
        check(bus.drop_cnt === 8'd255, "drop_sat", int'(bus.drop_cnt), 255);

        // Reset mid-operation with both buffers pending
        step(1'b0, 1'b1, 3'd5, 8'hA5, 1'b1, 3'd6, 8'hB6, x, y);
        step(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, x, y);
        idle(3);
        step(1'b0, 1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, x, y);
        step(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, x, y);
        check(bus.we3 === 1'b1 && bus.grant_b === 1'b0, "post_reset_grant_a",
              int'(bus.grant_b), 0);
        idle(3);

        // Randomized traffic with valid held until transfer
        ha = 1'b0; hb = 1'b0;
        ra_ = 3'd0; rb_ = 3'd0; da_ = 8'd0; db_ = 8'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, x, y);
                ha = 1'b0; hb = 1'b0;
            end else begin
                if (!ha && $urandom_range(0, 3) != 0) begin
                    ha = 1'b1; ra_ = 3'($urandom_range(0, 7)); da_ = 8'($urandom);
                end
                if (!hb && $urandom_range(0, 3) != 0) begin
                    hb = 1'b1; rb_ = 3'($urandom_range(0, 7)); db_ = 8'($urandom);
                end
                step(1'b0, ha, ra_, da_, hb, rb_, db_, x, y);
                if (x) ha = 1'b0;
                if (y) hb = 1'b0;
            end
        end
        idle(5);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port (we3/wa3/wd3) of the 8 x 8-bit register file between two independent requesters, A (datapath writeback) and B (loader/debug port). Each requester has a one-entry holding buffer behind a valid/ready handshake. A round-robin arbiter issues at most one write per cycle on registered outputs that drive the register file directly. Writes to R0, which is hardwired to zero, are consumed and counted but never issued.

## Interface
- No parameters; widths are fixed: 3-bit address, 8-bit data, 8-bit drop counter.
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A presents a write
- a_ready  out  1  A's buffer can accept this cycle
- a_addr  in  3  A's destination register
- a_data  in  8  A's write data
- b_valid, b_ready, b_addr, b_data  same as the A ports, for requester B
- we3  out  1  register file write enable (registered)
- wa3  out  3  register file write address (registered)
- wd3  out  8  register file write data (registered)
- grant_b  out  1  1 = write on we3/wa3/wd3 came from B, 0 = from A; valid when we3=1
- drop_cnt  out  8  saturating count of consumed writes addressed to R0

## Operation
- State per requester: pend_x (1 bit), addr_x (3 bits), data_x (8 bits). Global state: last_b (last grant was B), output registers, drop_cnt.
- Handshake: transfer when x_valid & x_ready at a posedge.
  - x_ready = ~pend_x | sel_x.
  - Combinational from state only; it never depends on x_valid.
  - Once x_valid is asserted, the requester holds valid, addr and data stable until the transfer.
- Selection, combinational from state:
  - Only pend_a set -> sel_a.
  - Only pend_b set -> sel_b.
  - Both set -> grant the requester not named by last_b (last_b=1 -> sel_a).
  - Neither set -> no selection.
- On posedge with a selection:
  - If the selected entry's addr != 0: we3<=1, wa3<=addr, wd3<=data, grant_b<=sel_b.
  - If the selected entry's addr == 0: we3<=0 and drop_cnt<=drop_cnt+1, saturating at 255.
  - In both cases the selected pend bit clears unless refilled the same edge, and last_b<=sel_b.
- On posedge with no selection: we3<=0; wa3, wd3 and grant_b hold their previous values.
- Simultaneous issue and refill of the same buffer: the new entry is loaded and pend stays 1.
- Both requesters writing the same address: writes issue in grant order, so the later grant wins in the register file.
- R0 drops count toward fairness, exactly like real writes.

## Timing
- Reset, effective on the first posedge with rst=1:
  - pend_a=pend_b=0, last_b=1.
  - we3=0, wa3=0, wd3=0, grant_b=0, drop_cnt=0.
  - a_ready=b_ready=1 from the following cycle.
- Reset asserted mid-operation discards buffered entries. we3 is 0 in the cycle after the reset edge. A write already presented on we3 in the reset cycle still reaches the register file at that edge.
- Latency for an uncontended request:
  - Accepted at edge N.
  - we3=1 during cycle N+1 to N+2 (issued at edge N+1).
  - Register file commits at edge N+2.
- Throughput:
  - One write per cycle aggregate.
  - A lone requester sustains 1 transfer/cycle.
  - Under contention each requester gets 1 write per 2 cycles. The loser's ready is low until it is granted.
- Worst-case wait for a pending entry is 1 cycle (two-requester round-robin).
- First conflict after reset is granted to A.

## Test plan
- Reset then idle: rst high for 2 cycles, then idle 5 cycles -> we3=0, drop_cnt=0, a_ready=b_ready=1 throughout.
- Single write: A sends addr=3, data=8'h5A at edge N -> we3=1, wa3=3, wd3=8'h5A, grant_b=0 in cycle N+1 only. Register file R3=8'h5A after edge N+2.
- Contention: A and B both valid every cycle, A addr=1/data=8'h11, B addr=2/data=8'h22, for 6 cycles -> we3 is 1 every cycle after the first. grant_b sequence is 0,1,0,1,... Each ready alternates.
- Streaming: B alone sends 4 back-to-back writes, addr 4..7 with data 8'h40..8'h43 -> b_ready stays 1. We3 stays high for 4 consecutive cycles with those address/data pairs in order.
- R0 drop: A writes addr=0, data=8'hFF, 3 times; then 300 more -> we3 stays 0. drop_cnt reads 3, then saturates at 255.
- Reset mid-operation: both buffers pending, rst pulsed 1 cycle -> no write issued afterward, pend bits cleared, the next conflict is granted to A.
